vx_wb_drain: RTL and testbench
==============================

Name: vx_wb_drain

Overview:
- Writeback-side consumer of the memory/writeback pipeline register.
- Accepts per-warp writeback packets: per-thread ALU result, memory result, PC_next, rd, wb select, thread mask and warp number.
- Selects the writeback data and buffers packets in a small FIFO.
- Drains one packet per cycle into the register-file write port under a ready handshake, and back-pressures the pipeline through a freeze output.

Parameters:
- NT, 4, threads per warp (lanes).
- NW, 8, number of warps; warp_num width is clog2(NW).
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_alu_result  in  NT*32  per-thread ALU result; lane i at bits [32i+31:32i].
- in_mem_result  in  NT*32  per-thread load data.
- in_PC_next  in  32  link value for JAL/JALR.
- in_rd  in  5  destination register.
- in_wb  in  2  00 none, 01 ALU, 10 MEM, 11 PC_next.
- in_valid  in  NT  per-thread active mask.
- in_warp_num  in  clog2(NW)  issuing warp.
- out_freeze  out  1  stall request to the upstream pipeline register.
- out_rf_we  out  NT  per-lane register-file write enable.
- out_rf_rd  out  5  write address.
- out_rf_warp  out  clog2(NW)  target warp register file.
- out_rf_data  out  NT*32  write data.
- in_rf_ready  in  1  register file accepts the write this cycle.
- out_count  out  clog2(DEPTH)+1  current occupancy, for debug and performance.

Behaviour:
- Request condition: req = (|in_valid) && in_wb != 0 && in_rd != 0. Packets failing req are dropped silently, since x0 is never written.
- Enqueue: enq = req && !full. Stored fields: rd, warp_num, valid mask, and data selected by wb.
  - 01 selects the ALU result per lane.
  - 10 selects the memory result per lane.
  - 11 replicates PC_next to all lanes.
  - Only selected data is stored; the raw wb code is not.
- Freeze and full:
  - out_freeze = full, where full = (count == DEPTH). It is combinational from registered count only, with no dependence on in_* ports.
  - While frozen, upstream holds its register, so the same packet is re-presented. The block takes it on the first non-full cycle.
- Dequeue and outputs:
  - out_rf_we = head.valid when !empty, else 0.
  - out_rf_rd, out_rf_warp and out_rf_data show the head entry. They hold their previous values when empty.
  - deq = !empty && in_rf_ready.
- Latency: a packet enqueued at edge N is presented at the output from cycle N+1, so minimum input-to-write latency is 1 cycle.
- Pointers: rd_ptr and wr_ptr are clog2(DEPTH) bits and wrap naturally modulo DEPTH. count is clog2(DEPTH)+1 bits.
- Simultaneous enq and deq: count unchanged and both pointers advance. This is legal when non-full, including count==1.
- When full with deq: freeze is still asserted this cycle, the input is not accepted, and count drops. Freeze deasserts the next cycle.
- When empty: deq is impossible and in_rf_ready is ignored.
- Reset (asynchronous, any time, including mid-drain):
  - rd_ptr, wr_ptr and count go to 0.
  - out_rf_we = 0, out_freeze = 0, out_count = 0.
  - out_rf_rd, out_rf_warp and out_rf_data reset to 0.
  - Buffered entries are discarded.
- No ordering change: strict FIFO across all warps.

Optional Feature:
- Macro: VX_WB_BYPASS_EN.
- Defined: when empty && enq && in_rf_ready, the input packet drives the out_rf_* ports combinationally in the same cycle and is not written to the FIFO. Latency becomes 0. If in_rf_ready is low, the packet is enqueued normally.
- Undefined: always 1-cycle latency through storage. out_rf_* never depend combinationally on in_* ports.

Decomposition:
- Shared package/header:
  - WB_NONE, WB_ALU, WB_MEM, WB_PC encodings.
  - NT/NW defaults and the NT_M1/NW_M1 derived widths.
  - The writeback entry struct: valid, rd, warp, data[NT].
- One sub-module is natural: vx_wb_fifo, a generic DEPTH x WIDTH synchronous FIFO with full/empty/count.
- The data-select mux and request qualification remain in vx_wb_drain.

Test Plan:
- Reset, with in_rf_ready held high.
  - Stimulus: after reset, one packet: wb=01, rd=5, warp=2, valid=4'b1011, lane results 0x10/0x20/0x30/0x40.
  - Response: next cycle out_rf_we=1011, rd=5, warp=2, data lanes 0x10..0x40. Following cycle out_rf_we=0.
- Select and drop rules.
  - Stimulus: wb=10 with mem lanes 0xAAAA_0000+i.
  - Response: out data equals mem lanes.
  - Stimulus: wb=11, PC_next=0x8000_0104.
  - Response: all four lanes equal 0x8000_0104.
  - Stimulus: rd=0, or wb=00, or valid=0.
  - Response: no write, and count stays 0.
- Fill and freeze.
  - Stimulus: in_rf_ready=0, 4 distinct packets.
  - Response: count=4, out_freeze=1, and a 5th packet held by upstream is not accepted.
  - Stimulus: raise ready.
  - Response: writes drain in order rd=1,2,3,4. Freeze drops one cycle after the first deq. The 5th packet then enqueues and writes as rd=5.
- Simultaneous enqueue/dequeue at count=2, for 8 cycles, with continuous packets and ready=1.
  - Response: count stays 2, and pointer wrap is exercised (wr_ptr wraps twice).
- Asynchronous reset mid-operation.
  - Stimulus: count=3; assert reset_n low between clock edges.
  - Response: out_rf_we=0, out_freeze=0 and out_count=0 immediately. After release, the first new packet is written and no stale entries appear.
- With VX_WB_BYPASS_EN defined.
  - Stimulus: empty, ready=1, packet rd=7.
  - Response: out_rf_we asserted in the same cycle and count stays 0.
  - Stimulus: same packet with ready=0.
  - Response: count becomes 1 and the write occurs next cycle.

Source files
------------

// File: rtl/vx_wb_drain_pkg.sv
// ----------------------------------------------------------------------------
// vx_wb_drain_pkg
// Shared definitions for the writeback drain block:
//   - writeback-select encodings (WB_NONE / WB_ALU / WB_MEM / WB_PC)
//   - default lane / warp / buffer sizes and their derived msb indices
//   - the writeback entry layout held in the drain buffer
// No ports (package only).
// ----------------------------------------------------------------------------
package vx_wb_drain_pkg;

   // Writeback source select codes carried on in_wb.
   localparam logic [1:0] WB_NONE = 2'b00;
   localparam logic [1:0] WB_ALU  = 2'b01;
   localparam logic [1:0] WB_MEM  = 2'b10;
   localparam logic [1:0] WB_PC   = 2'b11;

   // Default configuration.
   localparam int WB_NT    = 4;
   localparam int WB_NW    = 8;
   localparam int WB_DEPTH = 4;

   // Derived msb indices for the default configuration.
   localparam int NT_M1 = WB_NT - 1;
   localparam int NW_M1 = $clog2(WB_NW) - 1;

   // One buffered writeback: only the selected data is kept, never the wb code.
   typedef struct packed {
      logic [NT_M1:0]       valid;
      logic [4:0]           rd;
      logic [NW_M1:0]       warp;
      logic [NT_M1:0][31:0] data;
   } wb_entry_t;

endpackage

// File: rtl/vx_wb_fifo.sv
// ----------------------------------------------------------------------------
// vx_wb_fifo
// Generic DEPTH x WIDTH synchronous FIFO with a combinational head read.
// Pushes while full and pops while empty are ignored, so callers may drive
// push_i/pop_i from raw requests.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset (pointers and count only)
//   push_i   in   write wdata_i at the tail
//   pop_i    in   retire the head entry
//   wdata_i  in   WIDTH-bit write data
//   rdata_o  out  head entry (valid only when !empty_o)
//   full_o   out  count == DEPTH
//   empty_o  out  count == 0
//   count_o  out  occupancy, clog2(DEPTH)+1 bits
// ----------------------------------------------------------------------------
module vx_wb_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;
   logic             do_push_s;
   logic             do_pop_s;

   assign full_o    = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == {CW{1'b0}});
   assign count_o   = count_q;
   assign rdata_o   = mem_q[rd_ptr_q];
   assign do_push_s = push_i && !full_o;
   assign do_pop_s  = pop_i && !empty_o;

   // Next-state pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers; reset discards all buffered entries.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are meaningless outside [rd_ptr, wr_ptr) so it needs no reset.
   always_ff @(posedge clk_i) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/vx_wb_drain.sv
// ----------------------------------------------------------------------------
// vx_wb_drain
// Writeback-side consumer of the MEM/WB pipeline register. Qualifies each
// incoming per-warp packet, selects its writeback data (ALU / MEM / PC_next),
// buffers it in a small FIFO and drains one packet per cycle into the
// register-file write port under in_rf_ready. out_freeze back-pressures the
// upstream register while the buffer is full.
//
// Optional feature macro: VX_WB_BYPASS_EN
//   defined   - an accepted packet arriving while the buffer is empty and the
//               register file is ready goes straight to out_rf_* in the same
//               cycle without being stored (0-cycle latency).
//   undefined - every packet passes through storage (1-cycle latency) and
//               out_rf_* never depend combinationally on in_* ports.
//
// Ports:
//   clk            in   clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   in_alu_result  in   NT*32 per-lane ALU result, lane i at [32i+31:32i]
//   in_mem_result  in   NT*32 per-lane load data
//   in_PC_next     in   32-bit link value for JAL/JALR
//   in_rd          in   destination register
//   in_wb          in   writeback select (00 none, 01 ALU, 10 MEM, 11 PC)
//   in_valid       in   per-lane active mask
//   in_warp_num    in   issuing warp
//   out_freeze     out  stall request to upstream (buffer full)
//   out_rf_we      out  per-lane register-file write enable
//   out_rf_rd      out  write address
//   out_rf_warp    out  target warp register file
//   out_rf_data    out  NT*32 write data
//   in_rf_ready    in   register file accepts the write this cycle
//   out_count      out  buffer occupancy
// ----------------------------------------------------------------------------
module vx_wb_drain
   import vx_wb_drain_pkg::*;
#(
   parameter int NT    = WB_NT,
   parameter int NW    = WB_NW,
   parameter int DEPTH = WB_DEPTH
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NT*32-1:0]          in_alu_result,
   input  logic [NT*32-1:0]          in_mem_result,
   input  logic [31:0]               in_PC_next,
   input  logic [4:0]                in_rd,
   input  logic [1:0]                in_wb,
   input  logic [NT-1:0]             in_valid,
   input  logic [$clog2(NW)-1:0]     in_warp_num,
   output logic                      out_freeze,
   output logic [NT-1:0]             out_rf_we,
   output logic [4:0]                out_rf_rd,
   output logic [$clog2(NW)-1:0]     out_rf_warp,
   output logic [NT*32-1:0]          out_rf_data,
   input  logic                      in_rf_ready,
   output logic [$clog2(DEPTH):0]    out_count
);

   localparam int WW = $clog2(NW);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int DW = NT * 32;
   localparam int EW = NT + 5 + WW + DW;

   logic          req_s;
   logic          enq_s;
   logic          byp_s;
   logic          push_s;
   logic          pop_s;
   logic          full_s;
   logic          empty_s;
   logic [CW-1:0] count_s;

   logic [DW-1:0] sel_data_s;
   logic [EW-1:0] wdata_s;
   logic [EW-1:0] head_s;
   logic [NT-1:0] head_valid_s;
   logic [4:0]    head_rd_s;
   logic [WW-1:0] head_warp_s;
   logic [DW-1:0] head_data_s;

   logic [NT-1:0] shown_we_s;
   logic [4:0]    shown_rd_s;
   logic [WW-1:0] shown_warp_s;
   logic [DW-1:0] shown_data_s;

   logic [4:0]    hold_rd_q,   hold_rd_d;
   logic [WW-1:0] hold_warp_q, hold_warp_d;
   logic [DW-1:0] hold_data_q, hold_data_d;

   // x0 is never written, so packets with no lanes, no source or rd==0 are dropped.
   assign req_s = (|in_valid) && (in_wb != WB_NONE) && (in_rd != 5'd0);
   assign enq_s = req_s && !full_s;

`ifdef VX_WB_BYPASS_EN
   assign byp_s = empty_s && enq_s && in_rf_ready;
`else
   assign byp_s = 1'b0;
`endif

   // A bypassed packet is consumed directly and must not also be stored.
   assign push_s = enq_s && !byp_s;
   assign pop_s  = !empty_s && in_rf_ready;

   // Per-lane writeback data select; PC_next is replicated to every lane.
   always_comb begin
      sel_data_s = {DW{1'b0}};
      for (int i = 0; i < NT; i++) begin
         case (in_wb)
            WB_ALU:  sel_data_s[32*i +: 32] = in_alu_result[32*i +: 32];
            WB_MEM:  sel_data_s[32*i +: 32] = in_mem_result[32*i +: 32];
            WB_PC:   sel_data_s[32*i +: 32] = in_PC_next;
            default: sel_data_s[32*i +: 32] = 32'd0;
         endcase
      end
   end

   assign wdata_s = {in_valid, in_rd, in_warp_num, sel_data_s};

   vx_wb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .wdata_i (wdata_s),
      .rdata_o (head_s),
      .full_o  (full_s),
      .empty_o (empty_s),
      .count_o (count_s)
   );

   assign head_valid_s = head_s[EW-1 -: NT];
   assign head_rd_s    = head_s[DW+WW +: 5];
   assign head_warp_s  = head_s[DW +: WW];
   assign head_data_s  = head_s[DW-1:0];

   // Write-port view: head entry when buffered, bypassed input if enabled, else last shown values.
   always_comb begin
      shown_we_s   = {NT{1'b0}};
      shown_rd_s   = hold_rd_q;
      shown_warp_s = hold_warp_q;
      shown_data_s = hold_data_q;
      if (!empty_s) begin
         shown_we_s   = head_valid_s;
         shown_rd_s   = head_rd_s;
         shown_warp_s = head_warp_s;
         shown_data_s = head_data_s;
      end
`ifdef VX_WB_BYPASS_EN
      else if (byp_s) begin
         shown_we_s   = in_valid;
         shown_rd_s   = in_rd;
         shown_warp_s = in_warp_num;
         shown_data_s = sel_data_s;
      end
`endif
      else begin
         shown_we_s   = {NT{1'b0}};
         shown_rd_s   = hold_rd_q;
         shown_warp_s = hold_warp_q;
         shown_data_s = hold_data_q;
      end
   end

   // Whatever was shown this cycle is what the port keeps showing once the buffer empties.
   assign hold_rd_d   = shown_rd_s;
   assign hold_warp_d = shown_warp_s;
   assign hold_data_d = shown_data_s;

   // Hold registers for the address/warp/data ports while the buffer is empty.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_rd_q   <= 5'd0;
         hold_warp_q <= {WW{1'b0}};
         hold_data_q <= {DW{1'b0}};
      end else begin
         hold_rd_q   <= hold_rd_d;
         hold_warp_q <= hold_warp_d;
         hold_data_q <= hold_data_d;
      end
   end

   // Freeze is driven from the registered occupancy only, never from in_* ports.
   assign out_freeze  = full_s;
   assign out_count   = count_s;
   assign out_rf_we   = shown_we_s;
   assign out_rf_rd   = shown_rd_s;
   assign out_rf_warp = shown_warp_s;
   assign out_rf_data = shown_data_s;

endmodule

// File: tb/tb_vx_wb_drain.sv
// ----------------------------------------------------------------------------
// tb_vx_wb_drain
// Self-checking bench for vx_wb_drain. A queue-based reference model tracks
// the buffered packets; each scenario task drives stimulus and compares the
// DUT outputs against the model and against directed constants.
// ----------------------------------------------------------------------------
module tb_vx_wb_drain;

   localparam int NT    = 4;
   localparam int NW    = 8;
   localparam int DEPTH = 4;
   localparam int WW    = 3;
   localparam int CW    = 3;

   logic              clk;
   logic              reset_n;
   logic [NT*32-1:0]  in_alu_result;
   logic [NT*32-1:0]  in_mem_result;
   logic [31:0]       in_PC_next;
   logic [4:0]        in_rd;
   logic [1:0]        in_wb;
   logic [NT-1:0]     in_valid;
   logic [WW-1:0]     in_warp_num;
   logic              out_freeze;
   logic [NT-1:0]     out_rf_we;
   logic [4:0]        out_rf_rd;
   logic [WW-1:0]     out_rf_warp;
   logic [NT*32-1:0]  out_rf_data;
   logic              in_rf_ready;
   logic [CW-1:0]     out_count;

   vx_wb_drain #(.NT(NT), .NW(NW), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .in_alu_result (in_alu_result),
      .in_mem_result (in_mem_result),
      .in_PC_next    (in_PC_next),
      .in_rd         (in_rd),
      .in_wb         (in_wb),
      .in_valid      (in_valid),
      .in_warp_num   (in_warp_num),
      .out_freeze    (out_freeze),
      .out_rf_we     (out_rf_we),
      .out_rf_rd     (out_rf_rd),
      .out_rf_warp   (out_rf_warp),
      .out_rf_data   (out_rf_data),
      .in_rf_ready   (in_rf_ready),
      .out_count     (out_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [NT-1:0]    valid;
      logic [4:0]       rd;
      logic [WW-1:0]    warp;
      logic [NT*32-1:0] data;
   } ent_t;

   ent_t         mq[$];
   ent_t         last;
   int           n_chk;
   int           n_fail;
   logic [143:0] exp_all;
   wire  [143:0] obs_all = {out_count, out_freeze, out_rf_we, out_rf_rd, out_rf_warp, out_rf_data};

   function automatic logic [NT*32-1:0] sel_model(input logic [1:0] wb, input logic [NT*32-1:0] alu,
                                                  input logic [NT*32-1:0] mem, input logic [31:0] pc);
      logic [NT*32-1:0] r;
      r = '0;
      for (int i = 0; i < NT; i++) begin
         if (wb == 2'd1)      r[32*i +: 32] = alu[32*i +: 32];
         else if (wb == 2'd2) r[32*i +: 32] = mem[32*i +: 32];
         else if (wb == 2'd3) r[32*i +: 32] = pc;
         else                 r[32*i +: 32] = 32'd0;
      end
      return r;
   endfunction

   task automatic drive_pkt(input logic [1:0] wb, input logic [4:0] rd, input logic [WW-1:0] warp,
                            input logic [NT-1:0] valid);
      for (int i = 0; i < NT; i++) begin
         in_alu_result[32*i +: 32] = $urandom;
         in_mem_result[32*i +: 32] = $urandom;
      end
      in_PC_next  = $urandom;
      in_wb       = wb;
      in_rd       = rd;
      in_warp_num = warp;
      in_valid    = valid;
   endtask

   task automatic drive_rand_req();
      drive_pkt(2'($urandom_range(1, 3)), 5'($urandom_range(1, 31)), 3'($urandom_range(0, 7)),
                4'($urandom_range(1, 15)));
   endtask

   task automatic set_idle();
      in_valid = 4'b0000;
      in_wb    = 2'b00;
      in_rd    = 5'd0;
   endtask

   // Advance one clock and update the reference model; exp_all then holds the expected outputs.
   task automatic step();
      bit   req, byp, enq, deq;
      ent_t e;
      req = (|in_valid) && (in_wb != 2'b00) && (in_rd != 5'd0);
      byp = 1'b0;
`ifdef VX_WB_BYPASS_EN
      byp = req && (mq.size() == 0) && in_rf_ready;
`endif
      enq = req && (mq.size() < DEPTH) && !byp;
      deq = (mq.size() != 0) && in_rf_ready;
      e.valid = in_valid;
      e.rd    = in_rd;
      e.warp  = in_warp_num;
      e.data  = sel_model(in_wb, in_alu_result, in_mem_result, in_PC_next);
      if (byp) last = e;
      @(posedge clk);
      #1;
      if (deq) void'(mq.pop_front());
      if (enq) mq.push_back(e);
      if (mq.size() > 0) begin
         last    = mq[0];
         exp_all = {3'(mq.size()), (mq.size() == DEPTH), mq[0].valid, mq[0].rd, mq[0].warp, mq[0].data};
      end else begin
         exp_all = {3'd0, 1'b0, 4'b0000, last.rd, last.warp, last.data};
      end
   endtask

   task automatic test_reset();
      logic [127:0] exp_d;
      reset_n     = 1'b0;
      in_rf_ready = 1'b1;
      in_alu_result = '0;
      in_mem_result = '0;
      in_PC_next  = 32'd0;
      in_warp_num = 3'd0;
      set_idle();
      last = '{valid: 4'b0, rd: 5'd0, warp: 3'd0, data: 128'd0};
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if (obs_all !== 144'd0) begin
         n_fail++;
         $display("FAIL reset_state: obs=%h exp=0", obs_all);
      end
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      drive_pkt(2'b01, 5'd5, 3'd2, 4'b1011);
      in_alu_result = {32'h40, 32'h30, 32'h20, 32'h10};
      exp_d = {32'h40, 32'h30, 32'h20, 32'h10};
      step();
      set_idle();
      n_chk++;
      if (obs_all !== exp_all) begin
         n_fail++;
         $display("FAIL reset_first_model: obs=%h exp=%h", obs_all, exp_all);
      end
`ifndef VX_WB_BYPASS_EN
      n_chk++;
      if ({out_rf_we, out_rf_rd, out_rf_warp, out_rf_data} !== {4'b1011, 5'd5, 3'd2, exp_d}) begin
         n_fail++;
         $display("FAIL reset_first_write: we=%b rd=%0d warp=%0d data=%h exp we=1011 rd=5 warp=2 data=%h",
                  out_rf_we, out_rf_rd, out_rf_warp, out_rf_data, exp_d);
      end
`endif
      step();
      n_chk++;
      if (out_rf_we !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_we_clear: we=%b exp=0000", out_rf_we);
      end
   endtask

   task automatic test_select_drop();
      logic [127:0] exp_d;
      in_rf_ready = 1'b1;
      drive_pkt(2'b10, 5'd3, 3'd1, 4'b1111);
      for (int i = 0; i < NT; i++) in_mem_result[32*i +: 32] = 32'hAAAA_0000 + 32'(i);
      exp_d = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
      step();
      set_idle();
`ifndef VX_WB_BYPASS_EN
      n_chk++;
      if (out_rf_data !== exp_d) begin
         n_fail++;
         $display("FAIL select_mem: data=%h exp=%h", out_rf_data, exp_d);
      end
`endif
      n_chk++;
      if (obs_all !== exp_all) begin
         n_fail++;
         $display("FAIL select_mem_model: obs=%h exp=%h", obs_all, exp_all);
      end
      step();
      drive_pkt(2'b11, 5'd4, 3'd6, 4'b0101);
      in_PC_next = 32'h8000_0104;
      exp_d = {4{32'h8000_0104}};
      step();
      set_idle();
`ifndef VX_WB_BYPASS_EN
      n_chk++;
      if (out_rf_data !== exp_d) begin
         n_fail++;
         $display("FAIL select_pc: data=%h exp=%h", out_rf_data, exp_d);
      end
`endif
      n_chk++;
      if (obs_all !== exp_all) begin
         n_fail++;
         $display("FAIL select_pc_model: obs=%h exp=%h", obs_all, exp_all);
      end
      step();
      for (int k = 0; k < 3; k++) begin
         if (k == 0)      drive_pkt(2'b01, 5'd0, 3'd1, 4'b1111);
         else if (k == 1) drive_pkt(2'b00, 5'd9, 3'd1, 4'b1111);
         else             drive_pkt(2'b01, 5'd9, 3'd1, 4'b0000);
         step();
         n_chk++;
         if ({out_rf_we, out_count} !== {4'b0000, 3'd0}) begin
            n_fail++;
            $display("FAIL drop_%0d: we=%b count=%0d exp we=0000 count=0", k, out_rf_we, out_count);
         end
      end
      set_idle();
   endtask

   task automatic test_fill_freeze();
      int got[$];
      in_rf_ready = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         drive_rand_req();
         in_rd = 5'(k);
         step();
         n_chk++;
         if (obs_all !== exp_all) begin
            n_fail++;
            $display("FAIL fill_model_%0d: obs=%h exp=%h", k, obs_all, exp_all);
         end
      end
      n_chk++;
      if ({out_count, out_freeze} !== {3'd4, 1'b1}) begin
         n_fail++;
         $display("FAIL fill_full: count=%0d freeze=%b exp count=4 freeze=1", out_count, out_freeze);
      end
      drive_rand_req();
      in_rd = 5'd5;
      repeat (2) step();
      n_chk++;
      if ({out_count, out_freeze} !== {3'd4, 1'b1}) begin
         n_fail++;
         $display("FAIL fill_hold5: count=%0d freeze=%b exp count=4 freeze=1", out_count, out_freeze);
      end
      in_rf_ready = 1'b1;
      for (int it = 0; it < 12 && got.size() < 5; it++) begin
         if (out_rf_we != 4'b0000) got.push_back(int'(out_rf_rd));
         step();
         if (it == 0) begin
            n_chk++;
            if ({out_count, out_freeze} !== {3'd3, 1'b0}) begin
               n_fail++;
               $display("FAIL drain_freeze_drop: count=%0d freeze=%b exp count=3 freeze=0", out_count, out_freeze);
            end
         end
         if (it == 1) set_idle();
         n_chk++;
         if (obs_all !== exp_all) begin
            n_fail++;
            $display("FAIL drain_model_%0d: obs=%h exp=%h", it, obs_all, exp_all);
         end
      end
      n_chk++;
      if (got.size() != 5) begin
         n_fail++;
         $display("FAIL drain_len: writes=%0d exp=5", got.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            n_chk++;
            if (got[k] != k + 1) begin
               n_fail++;
               $display("FAIL drain_order_%0d: rd=%0d exp=%0d", k, got[k], k + 1);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      set_idle();
      in_rf_ready = 1'b1;
      repeat (3) step();
      in_rf_ready = 1'b0;
      repeat (2) begin
         drive_rand_req();
         step();
      end
      in_rf_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         drive_rand_req();
         step();
         n_chk++;
         if (out_count !== 3'd2 || obs_all !== exp_all) begin
            n_fail++;
            $display("FAIL b2b_%0d: obs=%h exp=%h", c, obs_all, exp_all);
         end
      end
      set_idle();
      repeat (3) step();
      n_chk++;
      if (obs_all !== exp_all) begin
         n_fail++;
         $display("FAIL b2b_drain: obs=%h exp=%h", obs_all, exp_all);
      end
   endtask

   task automatic test_async_reset();
      in_rf_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive_rand_req();
         in_rd = 5'(10 + k);
         step();
      end
      set_idle();
      n_chk++;
      if (out_count !== 3'd3) begin
         n_fail++;
         $display("FAIL arst_pre: count=%0d exp=3", out_count);
      end
      #2;
      reset_n = 1'b0;
      #1;
      mq.delete();
      last = '{valid: 4'b0, rd: 5'd0, warp: 3'd0, data: 128'd0};
      n_chk++;
      if (obs_all !== 144'd0) begin
         n_fail++;
         $display("FAIL arst_immediate: obs=%h exp=0", obs_all);
      end
      #3;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      in_rf_ready = 1'b1;
      drive_pkt(2'b01, 5'd9, 3'd5, 4'b1100);
      step();
      set_idle();
      n_chk++;
      if (obs_all !== exp_all) begin
         n_fail++;
         $display("FAIL arst_new_pkt: obs=%h exp=%h", obs_all, exp_all);
      end
      step();
      n_chk++;
      if ({out_rf_we, out_count} !== {4'b0000, 3'd0}) begin
         n_fail++;
         $display("FAIL arst_no_stale: we=%b count=%0d exp we=0000 count=0", out_rf_we, out_count);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         drive_pkt(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                   4'($urandom_range(0, 15)));
         if ($urandom_range(0, 3) == 0) set_idle();
         in_rf_ready = ($urandom_range(0, 2) != 0);
         step();
         n_chk++;
         if (obs_all !== exp_all) begin
            n_fail++;
            $display("FAIL random_%0d: obs=%h exp=%h", c, obs_all, exp_all);
         end
      end
      set_idle();
      in_rf_ready = 1'b1;
      repeat (5) step();
   endtask

`ifdef VX_WB_BYPASS_EN
   task automatic test_bypass();
      set_idle();
      in_rf_ready = 1'b1;
      repeat (5) step();
      drive_pkt(2'b01, 5'd7, 3'd3, 4'b0110);
      #1;
      n_chk++;
      if ({out_rf_we, out_rf_rd, out_count} !== {4'b0110, 5'd7, 3'd0}) begin
         n_fail++;
         $display("FAIL bypass_same_cycle: we=%b rd=%0d count=%0d exp we=0110 rd=7 count=0",
                  out_rf_we, out_rf_rd, out_count);
      end
      in_rf_ready = 1'b0;
      step();
      set_idle();
      n_chk++;
      if (out_count !== 3'd1 || obs_all !== exp_all) begin
         n_fail++;
         $display("FAIL bypass_not_ready: obs=%h exp=%h", obs_all, exp_all);
      end
      in_rf_ready = 1'b1;
      step();
   endtask
`endif

   initial begin
      n_chk  = 0;
      n_fail = 0;
      test_reset();
      test_select_drop();
      test_fill_freeze();
      test_back_to_back();
      test_async_reset();
      test_random();
`ifdef VX_WB_BYPASS_EN
      test_bypass();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
